// File: rtl/skel_pkg.sv
// skel_pkg: types shared by the frame readout path.
//   readout_state_t : readout FSM states.
//   beat_t          : one output beat as it sits in the skid buffer.
// Optional feature macro FRAME_READOUT_COORD_EN adds x/y fields to beat_t.
// PIX_W / COORD_W must match the top-level pixelWidth and $clog2(N);
// the package cannot see module parameters.
package skel_pkg;

    localparam int PIX_W   = 8;
    localparam int COORD_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } readout_state_t;

    typedef struct packed {
        logic [PIX_W-1:0]   pixel;
        logic               corner;
        logic               row_end;
        logic               last;
`ifdef FRAME_READOUT_COORD_EN
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
`endif
    } beat_t;

endpackage

// File: rtl/readout_skid_buffer.sv
// readout_skid_buffer: 2-entry valid/ready FIFO of beat_t.
//   clk, rst_n : clock, async active-low reset
//   i_push     : write i_beat (caller guarantees space)
//   i_beat     : entry to write
//   i_pop      : head consumed this cycle (ignored when empty)
//   o_head     : head entry, stable until popped
//   o_valid    : FIFO not empty
//   o_occ      : occupancy 0..2
module readout_skid_buffer
    import skel_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  beat_t      i_beat,
    input  logic       i_pop,
    output beat_t      o_head,
    output logic       o_valid,
    output logic [1:0] o_occ
);

    beat_t       r_mem [2];
    logic        r_wr;
    logic        r_rd;
    logic [1:0]  r_occ;
    logic        w_pop;

    assign w_pop   = i_pop && (r_occ != 2'd0);
    assign o_head  = r_mem[r_rd];
    assign o_valid = (r_occ != 2'd0);
    assign o_occ   = r_occ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_beat;
                r_wr        <= ~r_wr;
            end
            if (w_pop)
                r_rd <= ~r_rd;
            // push and pop together leave occupancy unchanged
            case ({i_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: rtl/frame_readout.sv
// frame_readout: streams an N*N frame from the image RAM and Harris RAM
// (shared dual-port read address) as a valid/ready beat stream in raster
// order, one pixel + corner flag per beat.
//   clk, rst_n          : clock, async active-low reset
//   start               : begin a frame (accepted only in IDLE)
//   busy, done          : frame in progress / 1-cycle completion pulse
//   rd_addr, rd_en      : RAM read port, data returns one cycle later
//   img_data, harris_data : RAM read data
//   out_valid/out_ready : output handshake
//   out_pixel, out_corner, out_row_end, out_last : beat payload
//   out_x, out_y        : beat column/row (only with FRAME_READOUT_COORD_EN)
// Optional feature macro: FRAME_READOUT_COORD_EN.
module frame_readout
    import skel_pkg::*;
#(
    parameter int N          = 8,
    parameter int bitSize    = 6,
    parameter int pixelWidth = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [bitSize:0]      rd_addr,
    output logic                  rd_en,
    input  logic [pixelWidth-1:0] img_data,
    input  logic [pixelWidth-1:0] harris_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [pixelWidth-1:0] out_pixel,
    output logic                  out_corner,
    output logic                  out_row_end,
`ifdef FRAME_READOUT_COORD_EN
    output logic [$clog2(N)-1:0]  out_x,
    output logic [$clog2(N)-1:0]  out_y,
`endif
    output logic                  out_last
);

    localparam int FRAME_PIXELS = N * N;
    localparam int AW           = bitSize + 1;
    localparam int XW           = $clog2(N);

    readout_state_t r_state, w_next;
    logic [AW-1:0]  r_issue;
    logic [AW-1:0]  r_beat;
    logic [XW-1:0]  r_x;
    logic [XW-1:0]  r_y;
    logic           r_inflight;

    beat_t          w_beat;
    beat_t          w_head;
    logic           w_valid;
    logic [1:0]     w_occ;
    logic           w_pop;
    logic [2:0]     w_used;
    logic           w_rd_en;

    assign w_pop = w_valid && out_ready;
    // A pop this cycle frees its slot in time for the data returning next
    // cycle, so counting it keeps one beat per cycle under continuous ready.
    assign w_used = 3'(w_occ) + 3'(r_inflight) - 3'(w_pop);

    always_comb begin
        w_next  = r_state;
        w_rd_en = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start)
                    w_next = FETCH;
            end
            FETCH: begin
                busy = 1'b1;
                if (w_used < 3'd2) begin
                    w_rd_en = 1'b1;
                    if (r_issue == AW'(FRAME_PIXELS - 1))
                        w_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (w_pop && w_head.last)
                    w_next = FINISH;
            end
            FINISH: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Beat tags come from the push-side position, not the read address.
    always_comb begin
        w_beat         = '0;
        w_beat.pixel   = img_data;
        w_beat.corner  = |harris_data;
        w_beat.row_end = (r_x == XW'(N - 1));
        w_beat.last    = (r_beat == AW'(FRAME_PIXELS - 1));
`ifdef FRAME_READOUT_COORD_EN
        w_beat.x       = r_x;
        w_beat.y       = r_y;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_issue    <= '0;
            r_beat     <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_inflight <= w_rd_en;
            if (r_state == IDLE && start) begin
                r_issue <= '0;
                r_beat  <= '0;
                r_x     <= '0;
                r_y     <= '0;
            end else begin
                if (w_rd_en)
                    r_issue <= r_issue + AW'(1);
                else if (r_state == FINISH)
                    r_issue <= '0;
                if (r_inflight) begin
                    r_beat <= r_beat + AW'(1);
                    if (r_x == XW'(N - 1)) begin
                        r_x <= '0;
                        r_y <= r_y + XW'(1);
                    end else begin
                        r_x <= r_x + XW'(1);
                    end
                end
            end
        end
    end

    readout_skid_buffer u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_inflight),
        .i_beat  (w_beat),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_valid (w_valid),
        .o_occ   (w_occ)
    );

    assign rd_addr     = r_issue;
    assign rd_en       = w_rd_en;
    assign out_valid   = w_valid;
    assign out_pixel   = w_head.pixel;
    assign out_corner  = w_head.corner;
    assign out_row_end = w_head.row_end;
    assign out_last    = w_head.last;
`ifdef FRAME_READOUT_COORD_EN
    assign out_x       = w_head.x;
    assign out_y       = w_head.y;
`endif

endmodule
